tq_bfly_stage: RTL

Parametrised first-stage butterfly/permute pipeline for the transform/quantisation path. Each beat carries one row of LANES signed coefficients. Forward mode applies an HEVC even/odd butterfly per block segment; inverse mode applies an even/odd reorder. It replaces a fixed 32-lane, always-accept stage with a valid/ready pipeline that has a skid buffer, and it adds optional block-end tagging. It sits between the TQ input buffer and the stage-2 multiplier array.

---
 rtl/tq_pkg.sv | 33 +++
 rtl/tq_bfly_stage_if.sv | 29 ++
 rtl/tq_bfly_core.sv | 67 ++++++
 rtl/tq_bfly_stage.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/tq_pkg.sv
// Shared definitions for the transform/quantisation path: transize codes,
// segment-size helper and the beat record carried through the butterfly stage.
package tq_pkg;

    localparam logic [1:0] TS_4  = 2'd0;
    localparam logic [1:0] TS_8  = 2'd1;
    localparam logic [1:0] TS_16 = 2'd2;
    localparam logic [1:0] TS_32 = 2'd3;

    // Widest row at the default geometry (32 lanes of 19-bit results).
    localparam int TQ_DATA_W = 32 * 19;

    typedef struct packed {
        logic [TQ_DATA_W-1:0] data;
        logic                 inverse;
        logic [1:0]           transize;
        logic                 last;
    } tq_beat_t;

    // Block size in lanes, clipped to the lanes available in one beat.
    function automatic int unsigned seg_size(input logic [1:0] transize,
                                             input int unsigned lanes);
        int unsigned s;
        case (transize)
            TS_4:    s = 4;
            TS_8:    s = 8;
            TS_16:   s = 16;
            default: s = 32;
        endcase
        return (s > lanes) ? lanes : s;
    endfunction

endpackage

// File: rtl/tq_bfly_stage_if.sv
// Handshake and data bundle of the first butterfly stage: upstream beat
// input on the i_* side, downstream beat output on the o_* side.
interface tq_bfly_stage_if #(
    parameter int LANES = 32,
    parameter int IW    = 16,
    parameter int OW    = 19
);
    logic                  i_valid;
    logic                  i_ready;
    logic                  i_inverse;
    logic [1:0]            i_transize;
    logic [LANES*IW-1:0]   i_data;
    logic                  o_valid;
    logic                  o_ready;
    logic [LANES*OW-1:0]   o_data;
    logic                  o_inverse;
    logic [1:0]            o_transize;
    logic                  o_last;

    modport master (
        output i_valid, i_inverse, i_transize, i_data, o_ready,
        input  i_ready, o_valid, o_data, o_inverse, o_transize, o_last
    );

    modport slave (
        input  i_valid, i_inverse, i_transize, i_data, o_ready,
        output i_ready, o_valid, o_data, o_inverse, o_transize, o_last
    );
endinterface

// File: rtl/tq_bfly_core.sv
// Combinational lane mapping: forward even/odd butterfly or inverse
// even/odd reorder, applied independently to each block segment of a row.
module tq_bfly_core
    import tq_pkg::*;
#(
    parameter int LANES = 32,
    parameter int IW    = 16,
    parameter int OW    = 19
) (
    input  logic                inverse,
    input  logic [1:0]          transize,
    input  logic [LANES*IW-1:0] coef,
    output logic [LANES*OW-1:0] result
);

    // Segment sizes are powers of two, so base and offset come from masking.
    always_comb begin
        int unsigned s;
        int unsigned half;
        int unsigned b;
        int unsigned k;
        int unsigned src_a;
        int unsigned src_b;
        logic signed [IW-1:0] a;
        logic signed [IW-1:0] c;
        logic signed [IW:0]   ax;
        logic signed [IW:0]   cx;
        logic signed [IW:0]   sum;

        result = '0;
        s      = seg_size(transize, LANES);
        half   = s >> 1;
        b      = 0;
        k      = 0;
        src_a  = 0;
        src_b  = 0;
        a      = '0;
        c      = '0;
        ax     = '0;
        cx     = '0;
        sum    = '0;

        for (int unsigned j = 0; j < LANES; j++) begin
            k = j & (s - 1);
            b = j - k;
            if (inverse) begin
                src_a = (k < half) ? (b + 2 * k) : (b + 2 * (k - half) + 1);
                src_b = src_a;
            end else begin
                src_a = b + k;
                src_b = b + s - 1 - k;
            end
            a   = coef[src_a*IW +: IW];
            c   = coef[src_b*IW +: IW];
            ax  = {a[IW-1], a};
            cx  = {c[IW-1], c};
            if (inverse)
                sum = ax;
            else if (k < half)
                sum = ax + cx;
            else
                sum = cx - ax;
            result[j*OW +: OW] = OW'(sum);
        end
    end

endmodule

// File: rtl/tq_bfly_stage.sv
// First butterfly/permute stage with valid/ready handshake and a skid buffer.
// Define TQ_BFLY_LAST_EN to build the row counter that drives o_last.
module tq_bfly_stage
    import tq_pkg::*;
#(
    parameter int LANES = 32,
    parameter int IW    = 16,
    parameter int OW    = 19
) (
    input  logic            clk,
    input  logic            rst,
    tq_bfly_stage_if.slave  bus
);

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } occ_t;

    occ_t                state;
    occ_t                state_nxt;
    tq_beat_t            out_q;
    tq_beat_t            skd_q;
    tq_beat_t            beat_in;
    logic [LANES*OW-1:0] core_data;
    logic                accept;
    logic                deliver;
    logic                load_out;
    logic                load_skd;
    logic                skd_to_out;
    logic                row_last;

    tq_bfly_core #(
        .LANES (LANES),
        .IW    (IW),
        .OW    (OW)
    ) u_core (
        .inverse  (bus.i_inverse),
        .transize (bus.i_transize),
        .coef     (bus.i_data),
        .result   (core_data)
    );

    assign accept  = bus.i_valid && (state != TWO);
    assign deliver = bus.o_ready && (state != EMPTY);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    // In ONE, a simultaneous accept and deliver overwrites OUT in place.
    always_comb begin
        state_nxt  = state;
        load_out   = 1'b0;
        load_skd   = 1'b0;
        skd_to_out = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt = ONE;
                    load_out  = 1'b1;
                end
            end
            ONE: begin
                if (accept && deliver) begin
                    load_out = 1'b1;
                end else if (accept) begin
                    state_nxt = TWO;
                    load_skd  = 1'b1;
                end else if (deliver) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (deliver) begin
                    state_nxt  = ONE;
                    skd_to_out = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        beat_in                     = '0;
        beat_in.data[LANES*OW-1:0]  = core_data;
        beat_in.inverse             = bus.i_inverse;
        beat_in.transize            = bus.i_transize;
        beat_in.last                = row_last;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q <= '0;
            skd_q <= '0;
        end else begin
            if (load_out)
                out_q <= beat_in;
            else if (skd_to_out)
                out_q <= skd_q;
            if (load_skd)
                skd_q <= beat_in;
        end
    end

`ifdef TQ_BFLY_LAST_EN
    logic [4:0] row_cnt;
    logic [4:0] row_cur;
    logic [4:0] row_max;
    logic [2:0] prev_side;

    // A change of mode or block size restarts the block on this beat.
    assign row_max  = 5'(seg_size(bus.i_transize, LANES) - 1);
    assign row_cur  = ({bus.i_inverse, bus.i_transize} != prev_side) ? 5'd0 : row_cnt;
    assign row_last = (row_cur == row_max);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_cnt   <= 5'd0;
            prev_side <= 3'd0;
        end else if (accept) begin
            row_cnt   <= row_last ? 5'd0 : row_cur + 5'd1;
            prev_side <= {bus.i_inverse, bus.i_transize};
        end
    end
`else
    assign row_last = 1'b0;
`endif

    assign bus.i_ready    = (state != TWO);
    assign bus.o_valid    = (state != EMPTY);
    assign bus.o_data     = out_q.data[LANES*OW-1:0];
    assign bus.o_inverse  = out_q.inverse;
    assign bus.o_transize = out_q.transize;
    assign bus.o_last     = out_q.last;

endmodule
